// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID decoupling queue: default datapath widths and the NOP encoding.
package if_id_queue_pkg;

    localparam int          DEF_PC_WIDTH    = 8;
    localparam int          DEF_INSTR_WIDTH = 16;
    localparam logic [15:0] NOP_INSTR       = 16'h0000;

endpackage

// File: rtl/fifo_ram_2p.sv
// DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.
module fifo_ram_2p #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; occupancy lives in the owner's count and pointers,
    // so a stale word is never presented as valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Credit-based queue between IF and ID: tracks one in-flight IMEM read, flushes on branch or IRST exit.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_WIDTH-1:0]      pc_in,
    input  logic [INSTR_WIDTH-1:0]   instr_in,
    input  logic                     irst_busy,
    input  logic                     branch_taken,
    output logic                     instruction_fetch_en,
    output logic                     id_valid,
    output logic [PC_WIDTH-1:0]      id_pc,
    output logic [INSTR_WIDTH-1:0]   id_instr,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    logic [CW-1:0]          count_q, count_d, remaining;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                   inflight_q, busy_q;
    logic [PC_WIDTH-1:0]    pc_q, id_pc_q;
    logic [INSTR_WIDTH-1:0] id_instr_q;
    logic                   valid_q;
    logic                   flush, push, pop;
    logic [EW-1:0]          rd_data, head_d;

    // Leaving IRST restarts IF from PC 0, so it discards the queue exactly like a taken branch.
    assign flush = branch_taken || (busy_q && !irst_busy);

    assign instruction_fetch_en = !rst && !irst_busy && !branch_taken &&
                                  ((count_q + CW'(inflight_q)) < CW'(DEPTH));

    // A fetch returning while IRST owns IMEM carries no trustworthy data.
    assign push = inflight_q && !irst_busy && !flush;
    assign pop  = valid_q && id_ready && !flush;

    fifo_ram_2p #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data ({pc_q, instr_in}),
        .rd_addr (rd_ptr_d),
        .rd_data (rd_data)
    );

    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        remaining = count_q - CW'(pop);
        head_d    = rd_data;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // The slot being written this edge is only the new head when nothing older survives.
        if (remaining == '0) head_d = {pc_q, instr_in};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            pc_q       <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= instruction_fetch_en;
            pc_q       <= pc_in;
            busy_q     <= irst_busy;
            valid_q    <= (count_d != '0);
            if (count_d != '0) begin
                id_pc_q    <= head_d[EW-1 -: PC_WIDTH];
                id_instr_q <= head_d[INSTR_WIDTH-1:0];
            end else begin
                id_instr_q <= INSTR_WIDTH'(NOP_INSTR);
            end
        end
    end

    assign id_valid = valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: the bench plays IF and IMEM, and a queue-based model checks every cycle.
module tb_if_id_queue;

    localparam int PCW   = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst, irst_busy, branch_taken, id_ready;
    logic [PCW-1:0] pc_in;
    logic [IW-1:0]  instr_in;
    logic           instruction_fetch_en, id_valid;
    logic [PCW-1:0] id_pc;
    logic [IW-1:0]  id_instr;
    logic [CW-1:0]  count;

    always #5 clk = ~clk;

    if_id_queue #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pc_in                (pc_in),
        .instr_in             (instr_in),
        .irst_busy            (irst_busy),
        .branch_taken         (branch_taken),
        .instruction_fetch_en (instruction_fetch_en),
        .id_valid             (id_valid),
        .id_pc                (id_pc),
        .id_instr             (id_instr),
        .id_ready             (id_ready),
        .count                (count)
    );

    // IF and a synchronous IMEM holding 16'hA000 + address.
    logic [PCW-1:0] if_pc, imem_addr, target;
    assign pc_in    = if_pc;
    assign instr_in = 16'hA000 + {8'h00, imem_addr};

    typedef struct {
        logic [PCW-1:0] pc;
        logic [IW-1:0]  instr;
    } entry_t;

    entry_t         mq[$];
    bit             m_inflight, m_busy_q, e_valid;
    logic [PCW-1:0] m_pc, e_pc;
    logic [IW-1:0]  e_instr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_fe();
        return !rst && !irst_busy && !branch_taken && (mq.size() + int'(m_inflight)) < DEPTH;
    endfunction

    task automatic model_edge(input bit fe);
        bit flush;
        if (rst) begin
            mq.delete();
            m_inflight = 0; m_busy_q = 0; m_pc = '0;
            e_valid = 0; e_pc = '0; e_instr = '0;
        end else begin
            flush = branch_taken || (m_busy_q && !irst_busy);
            if (flush) begin
                mq.delete();
            end else begin
                if (e_valid && id_ready) void'(mq.pop_front());
                if (m_inflight && !irst_busy) mq.push_back('{pc: m_pc, instr: instr_in});
            end
            m_inflight = fe;
            m_pc       = pc_in;
            m_busy_q   = irst_busy;
            e_valid    = (mq.size() > 0);
            if (e_valid) begin
                e_pc    = mq[0].pc;
                e_instr = mq[0].instr;
            end else begin
                e_instr = '0;
            end
        end
        imem_addr = if_pc;
        if (rst)               if_pc = '0;
        else if (branch_taken) if_pc = target;
        else if (irst_busy)    if_pc = '0;
        else if (fe)           if_pc = if_pc + 8'd1;
    endtask

    // One cycle: compare on the falling edge, then advance model, IF and IMEM just after the rising edge.
    task automatic tick();
        bit fe;
        @(negedge clk);
        fe = model_fe();
        check("fetch_en", {31'b0, instruction_fetch_en}, {31'b0, fe});
        check("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
        check("id_pc",    {24'b0, id_pc},    {24'b0, e_pc});
        check("id_instr", {16'b0, id_instr}, {16'b0, e_instr});
        check("count",    {30'b0, count},    mq.size());
        @(posedge clk);
        #1;
        model_edge(fe);
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!e_valid && n < max_cycles) begin
            tick();
            n++;
        end
        if (!e_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: no head entry within %0d cycles", max_cycles);
        end
    endtask

    initial begin
        rst = 1'b1; irst_busy = 1'b0; branch_taken = 1'b0; id_ready = 1'b0;
        if_pc = '0; imem_addr = '0; target = '0;
        @(posedge clk);
        #1;
        model_edge(1'b0);
        tick();
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_count", {30'b0, count},    32'd0);
        check("rst_pc",    {24'b0, id_pc},    32'd0);
        check("rst_instr", {16'b0, id_instr}, 32'd0);

        // Streaming with ID always ready.
        rst = 1'b0; id_ready = 1'b1;
        #1;
        check("fe_cycle0", {31'b0, instruction_fetch_en}, 32'd1);
        tick(); tick();
        check("first_valid", {31'b0, id_valid}, 32'd1);
        check("first_pc",    {24'b0, id_pc},    32'd0);
        check("first_instr", {16'b0, id_instr}, 32'hA000);
        repeat (8) tick();

        // Backpressure fills the queue, then releases in order.
        id_ready = 1'b0;
        repeat (6) tick();
        check("stall_count", {30'b0, count}, 32'd2);
        check("stall_fe",    {31'b0, instruction_fetch_en}, 32'd0);
        id_ready = 1'b1;
        repeat (6) tick();

        // Taken branch with a full queue.
        id_ready = 1'b0;
        repeat (4) tick();
        check("pre_br_count", {30'b0, count}, 32'd2);
        branch_taken = 1'b1; target = 8'h40;
        tick();
        branch_taken = 1'b0;
        check("br_count", {30'b0, count},    32'd0);
        check("br_valid", {31'b0, id_valid}, 32'd0);
        id_ready = 1'b1;
        wait_valid(10);
        check("br_target_pc",    {24'b0, id_pc},    32'h40);
        check("br_target_instr", {16'b0, id_instr}, 32'hA040);

        // Taken branch while a fetch is in flight during streaming.
        repeat (3) tick();
        branch_taken = 1'b1; target = 8'h80;
        tick();
        branch_taken = 1'b0;
        wait_valid(10);
        check("br2_target_pc", {24'b0, id_pc}, 32'h80);
        repeat (4) tick();

        // IRST owns the fetch path for 10 cycles; held entries drain.
        id_ready = 1'b0;
        repeat (2) tick();
        id_ready = 1'b1;
        irst_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("irst_fe", {31'b0, instruction_fetch_en}, 32'd0);
        end
        check("irst_drained", {31'b0, id_valid}, 32'd0);
        irst_busy = 1'b0;
        wait_valid(10);
        check("irst_restart_pc",    {24'b0, id_pc},    32'd0);
        check("irst_restart_instr", {16'b0, id_instr}, 32'hA000);

        // Sustained push/pop across pointer wrap.
        repeat (20) tick();

        // Reset while full.
        id_ready = 1'b0;
        repeat (4) tick();
        check("pre_rst_count", {30'b0, count}, 32'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'b0, id_valid}, 32'd0);
        check("mid_rst_count", {30'b0, count},    32'd0);
        check("mid_rst_pc",    {24'b0, id_pc},    32'd0);
        check("mid_rst_instr", {16'b0, id_instr}, 32'd0);
        check("mid_rst_fe",    {31'b0, instruction_fetch_en}, 32'd0);
        rst = 1'b0; id_ready = 1'b1;
        tick();
        check("post_rst_count", {30'b0, count}, 32'd0);
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
